piece_drop: RTL and testbench

PIECE_DROP -- requirements
Module: piece_drop

---
 rtl/piece_drop.sv | 188 ++++++++++++++++++
 tb/tb_piece_drop.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/piece_drop.sv
`default_nettype none
// ============================================================================
// Module   : piece_drop
// Purpose  : Connect-four style drop engine. Accepts a column, checks that it
//            is legal, animates the piece falling row by row, commits it to
//            the board, then offers the result to a win checker and hands the
//            turn to the other player once the checker accepts it.
// Ports    : clk            - rising-edge clock
//            reset          - asynchronous active-low reset
//            coulumnSelect  - requested column
//            confirmMove    - one-cycle drop request (honoured only when idle)
//            newGame        - synchronous clear, highest priority
//            resultReady    - win checker ready for the move result
//            busy           - engine not idle
//            moveValid      - pulse: move committed
//            moveRejected   - pulse: illegal or full column
//            fallingActive  - animation in progress
//            fallingRow     - current animation row
//            dropCol/Row/Player - last committed piece
//            resultValid    - move result offered to the win checker
//            currentPlayer  - player to move
//            boardP0/boardP1 - per-player occupancy, bit row*NUM_COLS+col
//            boardFull      - every cell occupied
// Revision : 1.0 - initial release
// ============================================================================
module piece_drop #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               coulumnSelect,
  input  logic                     confirmMove,
  input  logic                     newGame,
  input  logic                     resultReady,
  output logic                     busy,
  output logic                     moveValid,
  output logic                     moveRejected,
  output logic                     fallingActive,
  output logic [2:0]               fallingRow,
  output logic [2:0]               dropCol,
  output logic [2:0]               dropRow,
  output logic                     dropPlayer,
  output logic                     resultValid,
  output logic                     currentPlayer,
  output logic [NUM_COLS*NUM_ROWS-1:0] boardP0,
  output logic [NUM_COLS*NUM_ROWS-1:0] boardP1,
  output logic                     boardFull
);

  localparam int c_CELLS = NUM_COLS * NUM_ROWS;
  localparam int c_IDX_W = $clog2(c_CELLS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    FALL     = 3'd2,
    COMMIT   = 3'd3,
    WAIT_ACK = 3'd4,
    FULL     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2:0]         r_colReg;
  logic [2:0]         r_fallingRow;
  logic [2:0]         r_height [NUM_COLS];
  logic [5:0]         r_moveCount;
  logic [2:0]         r_dropCol;
  logic [2:0]         r_dropRow;
  logic               r_dropPlayer;
  logic               r_currentPlayer;
  logic [c_CELLS-1:0] r_boardP0;
  logic [c_CELLS-1:0] r_boardP1;

  logic               w_colInRange;
  logic [2:0]         w_colHeight;
  logic               w_legal;
  logic [c_IDX_W-1:0] w_cellIdx;

  // Out-of-range columns must never index the height array.
  assign w_colInRange = (r_colReg < 3'(NUM_COLS));
  assign w_colHeight  = w_colInRange ? r_height[r_colReg] : 3'd0;
  assign w_legal      = w_colInRange && (w_colHeight != 3'(NUM_ROWS));
  assign w_cellIdx    = c_IDX_W'(r_fallingRow) * c_IDX_W'(NUM_COLS) + c_IDX_W'(r_colReg);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next state and per-state strobes. Strobes are decoded from the state so
  // they fall to 0 the instant reset forces the state to IDLE.
  always_comb begin
    w_nextState   = r_state;
    moveValid     = 1'b0;
    moveRejected  = 1'b0;
    resultValid   = 1'b0;
    case (r_state)
      IDLE:     if (confirmMove) w_nextState = CHECK;
      CHECK: begin
        moveRejected = !w_legal;
        w_nextState  = w_legal ? FALL : IDLE;
      end
      FALL:     if (r_fallingRow == w_colHeight) w_nextState = COMMIT;
      COMMIT: begin
        moveValid   = 1'b1;
        w_nextState = WAIT_ACK;
      end
      WAIT_ACK: begin
        resultValid = 1'b1;
        if (resultReady)
          w_nextState = (r_moveCount == 6'(c_CELLS)) ? FULL : IDLE;
      end
      FULL:     w_nextState = FULL;
      default:  w_nextState = IDLE;
    endcase
    // A new game aborts whatever is in flight, including a COMMIT cycle.
    if (newGame) begin
      w_nextState  = IDLE;
      moveValid    = 1'b0;
      moveRejected = 1'b0;
    end
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_colReg        <= 3'd0;
      r_fallingRow    <= 3'd0;
      r_moveCount     <= 6'd0;
      r_dropCol       <= 3'd0;
      r_dropRow       <= 3'd0;
      r_dropPlayer    <= 1'b0;
      r_currentPlayer <= 1'b0;
      r_boardP0       <= '0;
      r_boardP1       <= '0;
      for (int i = 0; i < NUM_COLS; i++) r_height[i] <= 3'd0;
    end else if (newGame) begin
      r_colReg        <= 3'd0;
      r_fallingRow    <= 3'd0;
      r_moveCount     <= 6'd0;
      r_dropCol       <= 3'd0;
      r_dropRow       <= 3'd0;
      r_dropPlayer    <= 1'b0;
      r_currentPlayer <= 1'b0;
      r_boardP0       <= '0;
      r_boardP1       <= '0;
      for (int i = 0; i < NUM_COLS; i++) r_height[i] <= 3'd0;
    end else begin
      case (r_state)
        IDLE:  if (confirmMove) r_colReg <= coulumnSelect;
        CHECK: if (w_legal) r_fallingRow <= 3'(NUM_ROWS - 1);
        FALL:  if (r_fallingRow != w_colHeight) r_fallingRow <= r_fallingRow - 3'd1;
        COMMIT: begin
          if (r_currentPlayer) r_boardP1[w_cellIdx] <= 1'b1;
          else                 r_boardP0[w_cellIdx] <= 1'b1;
          // COMMIT is only reachable for an in-range, non-full column; the
          // saturation guards keep the counters bounded regardless.
          if (w_colInRange && r_height[r_colReg] != 3'(NUM_ROWS))
            r_height[r_colReg] <= r_height[r_colReg] + 3'd1;
          if (r_moveCount != 6'(c_CELLS))
            r_moveCount <= r_moveCount + 6'd1;
          r_dropCol    <= r_colReg;
          r_dropRow    <= r_fallingRow;
          r_dropPlayer <= r_currentPlayer;
        end
        WAIT_ACK: if (resultReady) r_currentPlayer <= ~r_currentPlayer;
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != IDLE);
  assign fallingActive = (r_state == FALL);
  assign boardFull     = (r_state == FULL);
  assign fallingRow    = r_fallingRow;
  assign dropCol       = r_dropCol;
  assign dropRow       = r_dropRow;
  assign dropPlayer    = r_dropPlayer;
  assign currentPlayer = r_currentPlayer;
  assign boardP0       = r_boardP0;
  assign boardP1       = r_boardP1;

endmodule
`default_nettype wire

// File: tb/tb_piece_drop.sv
`default_nettype none
// ============================================================================
// Module   : tb_piece_drop
// Purpose  : Self-checking bench for piece_drop. A reference model holds
//            column heights, per-player boards, move count and turn as plain
//            arrays and derives expected latency and drop results from the
//            game rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piece_drop;

  localparam int c_COLS  = 7;
  localparam int c_ROWS  = 6;
  localparam int c_CELLS = c_COLS * c_ROWS;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  coulumnSelect;
  logic        confirmMove;
  logic        newGame;
  logic        resultReady;
  logic        busy, moveValid, moveRejected, fallingActive;
  logic [2:0]  fallingRow, dropCol, dropRow;
  logic        dropPlayer, resultValid, currentPlayer, boardFull;
  logic [c_CELLS-1:0] boardP0, boardP1;

  piece_drop #(.NUM_COLS(c_COLS), .NUM_ROWS(c_ROWS)) dut (
    .clk(clk), .reset(reset), .coulumnSelect(coulumnSelect),
    .confirmMove(confirmMove), .newGame(newGame), .resultReady(resultReady),
    .busy(busy), .moveValid(moveValid), .moveRejected(moveRejected),
    .fallingActive(fallingActive), .fallingRow(fallingRow),
    .dropCol(dropCol), .dropRow(dropRow), .dropPlayer(dropPlayer),
    .resultValid(resultValid), .currentPlayer(currentPlayer),
    .boardP0(boardP0), .boardP1(boardP1), .boardFull(boardFull)
  );

  always #5 clk = ~clk;

  // Reference model
  int                 mH [c_COLS];
  logic [c_CELLS-1:0] mB0, mB1;
  logic               mPlayer;
  int                 mCount;
  int                 nAsserts = 0;
  int                 nFail    = 0;

  task automatic modelClear();
    for (int c = 0; c < c_COLS; c++) mH[c] = 0;
    mB0 = '0; mB1 = '0; mPlayer = 1'b0; mCount = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chkBoards(input string tag);
    chk({tag, "_p0"}, 64'(boardP0), 64'(mB0));
    chk({tag, "_p1"}, 64'(boardP1), 64'(mB1));
  endtask

  task automatic doNewGame();
    newGame = 1'b1; tick(); newGame = 1'b0;
    modelClear();
    chk("ng_busy", 64'(busy), 64'd0);
    chk("ng_full", 64'(boardFull), 64'd0);
    chk("ng_player", 64'(currentPlayer), 64'd0);
    chk("ng_drop", 64'({dropCol, dropRow, dropPlayer}), 64'd0);
    chkBoards("ng");
  endtask

  // One complete move attempt: confirm, wait for the outcome, hold the ack
  // off for ackDelay cycles (optionally poking confirmMove meanwhile), ack.
  task automatic doMove(input int col, input int ackDelay, input bit poke);
    int  h, n, fa;
    logic [6:0] expDrop;
    coulumnSelect = 3'(col); confirmMove = 1'b1; tick(); confirmMove = 1'b0;
    if (mCount == c_CELLS) begin
      chk("full_noreject", 64'(moveRejected), 64'd0);
      chk("full_busy", 64'(busy), 64'd1);
      tick();
      chk("full_stay", 64'(boardFull), 64'd1);
      chkBoards("full");
    end else if (col >= c_COLS || mH[col] >= c_ROWS) begin
      chk("reject_pulse", 64'(moveRejected), 64'd1);
      tick();
      chk("reject_once", 64'(moveRejected), 64'd0);
      chk("reject_idle", 64'(busy), 64'd0);
      chkBoards("reject");
    end else begin
      h = mH[col]; n = 1; fa = 0;
      while (moveValid !== 1'b1 && n < 30) begin
        if (fallingActive === 1'b1) fa++;
        tick(); n++;
      end
      chk("latency", 64'(n), 64'(8 - h));
      chk("fall_len", 64'(fa), 64'(6 - h));
      if (mPlayer) mB1[h*c_COLS+col] = 1'b1;
      else         mB0[h*c_COLS+col] = 1'b1;
      mH[col]++; mCount++;
      expDrop = {3'(col), 3'(h), mPlayer};
      tick();
      chk("rv_first", 64'(resultValid), 64'd1);
      chk("drop", 64'({dropCol, dropRow, dropPlayer}), 64'(expDrop));
      chkBoards("commit");
      for (int k = 0; k < ackDelay; k++) begin
        if (poke && k == 3) begin
          coulumnSelect = 3'($urandom_range(0, 6)); confirmMove = 1'b1;
        end
        tick(); confirmMove = 1'b0;
        chk("hold_rv", 64'(resultValid), 64'd1);
        chk("hold_drop", 64'({dropCol, dropRow, dropPlayer}), 64'(expDrop));
      end
      resultReady = 1'b1; tick(); resultReady = 1'b0;
      mPlayer = ~mPlayer;
      chk("ack_player", 64'(currentPlayer), 64'(mPlayer));
      chk("ack_full", 64'(boardFull), 64'(mCount == c_CELLS));
      chk("ack_busy", 64'(busy), 64'(mCount == c_CELLS));
      chkBoards("ack");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  col, seen;
    reset = 1'b0; coulumnSelect = 3'd0; confirmMove = 1'b0;
    newGame = 1'b0; resultReady = 1'b0;
    modelClear();
    #3;
    chk("rst_strobes", 64'({busy, moveValid, moveRejected, fallingActive, resultValid, boardFull}), 64'd0);
    chk("rst_regs", 64'({fallingRow, dropCol, dropRow, dropPlayer, currentPlayer}), 64'd0);
    chkBoards("rst");
    tick(); reset = 1'b1;

    // Empty board, column 3
    doMove(3, 0, 1'b0);
    chk("col3_bit", 64'(boardP0[3]), 64'd1);

    // Fill column 0, seventh attempt rejected
    doNewGame();
    for (int i = 0; i < 7; i++) doMove(0, 0, 1'b0);

    // Out-of-range column
    doMove(7, 0, 1'b0);

    // Stalled ack with an ignored confirm in the window
    doMove(4, 10, 1'b1);

    // newGame mid-FALL
    doNewGame();
    coulumnSelect = 3'd2; confirmMove = 1'b1; tick(); confirmMove = 1'b0;
    tick(); tick();
    chk("ngfall_active", 64'(fallingActive), 64'd1);
    newGame = 1'b1; tick(); newGame = 1'b0;
    chk("ngfall_idle", 64'(busy), 64'd0);
    chk("ngfall_player", 64'(currentPlayer), 64'd0);
    chkBoards("ngfall");
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (moveValid === 1'b1) seen++;
      tick();
    end
    chk("ngfall_nomv", 64'(seen), 64'd0);
    chkBoards("ngfall_after");

    // Random fill of the whole board, with occasional illegal requests
    doNewGame();
    while (mCount < c_CELLS) begin
      if ($urandom_range(0, 7) == 0) doMove(7, 0, 1'b0);
      do col = $urandom_range(0, c_COLS - 1); while (mH[col] >= c_ROWS);
      doMove(col, $urandom_range(0, 2), 1'b0);
    end
    doMove($urandom_range(0, 6), 0, 1'b0);
    doMove($urandom_range(0, 7), 0, 1'b0);
    doNewGame();

    // Asynchronous reset mid-move
    doMove(1, 0, 1'b0);
    coulumnSelect = 3'd1; confirmMove = 1'b1; tick(); confirmMove = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_strobes", 64'({busy, moveValid, moveRejected, fallingActive, resultValid, boardFull}), 64'd0);
    chk("arst_regs", 64'({fallingRow, dropCol, dropRow, dropPlayer, currentPlayer}), 64'd0);
    modelClear();
    chkBoards("arst");
    tick(); reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (moveValid === 1'b1) seen++;
      tick();
    end
    chk("arst_nomv", 64'(seen), 64'd0);
    doMove(5, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
`default_nettype wire
